// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 10;

  // The state remembers which port was granted last.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } arb_state_e;

endpackage

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational grant decision for the RAM arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin on conflict; default is fixed port-B priority.
module arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
  input  logic       b_lock,
  input  arb_state_e state,
  output logic       a_gnt,
  output logic       b_gnt
);

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (a_req && b_req) begin
      if (state == OWN_B && b_lock) begin
        b_gnt = 1'b1;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        // IDLE behaves like "A was last", so B wins from IDLE.
        if (state == OWN_B) a_gnt = 1'b1;
        else                b_gnt = 1'b1;
`else
        b_gnt = 1'b1;
`endif
      end
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-port RAM between an instruction-fetch port (A) and a data port (B).
// Optional macro ARB_ROUND_ROBIN_EN (see arb_pick) changes the conflict policy.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_req,
  input  logic [DEPTH-1:0] a_addr,
  output logic             a_gnt,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_valid,
  input  logic             b_req,
  input  logic             b_wena,
  input  logic             b_lock,
  input  logic [DEPTH-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_gnt,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_valid,
  output logic             ram_ena,
  output logic             ram_wena,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic             stall
);

  arb_state_e       state_q, state_d;
  logic             a_valid_q, b_valid_q;
  logic [WIDTH-1:0] a_rdata_q, b_rdata_q;

  arb_pick u_pick (
    .a_req  (a_req),
    .b_req  (b_req),
    .b_lock (b_lock),
    .state  (state_q),
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  assign ram_ena   = a_gnt | b_gnt;
  assign ram_wena  = b_gnt & b_wena;
  assign ram_addr  = b_gnt ? b_addr : a_addr;
  assign ram_wdata = b_wdata;
  assign stall     = (a_req & ~a_gnt) | (b_req & ~b_gnt);

  // A lone request is always granted, so "no grant" means "no request".
  always_comb begin
    state_d = IDLE;
    if (a_gnt)                          state_d = OWN_A;
    else if (b_gnt)                     state_d = OWN_B;
    else if (state_q == OWN_B && b_lock) state_d = OWN_B;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      a_valid_q <= a_gnt;
      b_valid_q <= b_gnt & ~b_wena;
      if (a_gnt)           a_rdata_q <= ram_rdata;
      if (b_gnt && !b_wena) b_rdata_q <= ram_rdata;
    end
  end

  assign a_valid = a_valid_q;
  assign a_rdata = a_rdata_q;
  assign b_valid = b_valid_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: external RAM, behavioural model, directed and random stimulus.
module tb_ram_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 10;
  localparam int WORDS = 1 << DEPTH;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_req, b_req, b_wena, b_lock;
  logic [DEPTH-1:0] a_addr, b_addr;
  logic [WIDTH-1:0] b_wdata;
  logic             a_gnt, a_valid, b_gnt, b_valid;
  logic [WIDTH-1:0] a_rdata, b_rdata;
  logic             ram_ena, ram_wena, stall;
  logic [DEPTH-1:0] ram_addr;
  logic [WIDTH-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_rdata(a_rdata), .a_valid(a_valid),
    .b_req(b_req), .b_wena(b_wena), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_valid(b_valid),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall(stall)
  );

  function automatic logic [WIDTH-1:0] init_word(input int i);
    if (i == 4) return 32'h1234_5678;
    return 32'hA5A5_0000 ^ WIDTH'(i * 32'h0001_0003);
  endfunction

  // External single-port RAM: synchronous write, combinational read.
  logic [WIDTH-1:0] mem     [WORDS];
  logic [WIDTH-1:0] ref_mem [WORDS];
  initial for (int i = 0; i < WORDS; i++) begin
    mem[i]     <= init_word(i);
    ref_mem[i] <= init_word(i);
  end
  always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0=nobody, 1=A, 2=B.
  int               owner = 0;
  logic             m_ga, m_gb;
  logic             ea_v = 1'b0, eb_v = 1'b0;
  logic [WIDTH-1:0] ea_d = '0, eb_d = '0;

  always_comb begin
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (a_req && b_req) begin
      if (owner == 2 && b_lock) m_gb = 1'b1;
      else if (RR && owner == 2) m_ga = 1'b1;
      else m_gb = 1'b1;
    end else begin
      m_ga = a_req;
      m_gb = b_req;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 0; ea_v <= 1'b0; eb_v <= 1'b0; ea_d <= '0; eb_d <= '0;
    end else begin
      ea_v <= m_ga;
      if (m_ga) ea_d <= ref_mem[a_addr];
      eb_v <= m_gb && !b_wena;
      if (m_gb && !b_wena) eb_d <= ref_mem[b_addr];
      if (m_gb && b_wena) ref_mem[b_addr] <= b_wdata;
      if (m_ga) owner <= 1;
      else if (m_gb) owner <= 2;
      else if (!(owner == 2 && b_lock)) owner <= 0;
    end
  end

  always @(negedge clk) begin
    logic exp_stall;
    exp_stall = (a_req && !m_ga) || (b_req && !m_gb);
    chk("a_gnt", WIDTH'(a_gnt), WIDTH'(m_ga));
    chk("b_gnt", WIDTH'(b_gnt), WIDTH'(m_gb));
    chk("one_hot", WIDTH'(a_gnt & b_gnt), '0);
    chk("stall", WIDTH'(stall), WIDTH'(exp_stall));
    chk("ram_ena", WIDTH'(ram_ena), WIDTH'(m_ga | m_gb));
    chk("ram_wena", WIDTH'(ram_wena), WIDTH'(m_gb & b_wena));
    if (m_ga || m_gb) chk("ram_addr", WIDTH'(ram_addr), WIDTH'(m_gb ? b_addr : a_addr));
    if (m_gb && b_wena) chk("ram_wdata", ram_wdata, b_wdata);
    chk("a_valid", WIDTH'(a_valid), WIDTH'(ea_v));
    chk("b_valid", WIDTH'(b_valid), WIDTH'(eb_v));
    chk("a_rdata", a_rdata, ea_d);
    chk("b_rdata", b_rdata, eb_d);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ga, gb;
    rst_n = 1'b0; a_req = 0; b_req = 0; b_wena = 0; b_lock = 0;
    a_addr = '0; b_addr = '0; b_wdata = '0;
    step(); step();
    chk("rst_a_valid", WIDTH'(a_valid), '0);
    chk("rst_a_rdata", a_rdata, '0);
    chk("rst_b_valid", WIDTH'(b_valid), '0);
    rst_n = 1'b1;

    // Single A read from 0x004.
    a_req = 1; a_addr = 10'h004; #1;
    chk("t1_a_gnt", WIDTH'(a_gnt), 1);
    chk("t1_stall", WIDTH'(stall), 0);
    step(); a_req = 0;
    chk("t1_a_valid", WIDTH'(a_valid), 1);
    chk("t1_a_rdata", a_rdata, 32'h1234_5678);
    step();
    chk("t1_a_valid_drop", WIDTH'(a_valid), 0);

    // Conflict from IDLE.
    a_req = 1; a_addr = 10'h008; b_req = 1; b_wena = 0; b_addr = 10'h020; #1;
    chk("t2_b_gnt", WIDTH'(b_gnt), 1);
    chk("t2_a_gnt", WIDTH'(a_gnt), 0);
    chk("t2_stall", WIDTH'(stall), 1);
    step();
    chk("t2_b_valid", WIDTH'(b_valid), 1);
    chk("t2_b_rdata", b_rdata, init_word(32));
    chk("t2_a_gnt_next", WIDTH'(a_gnt), WIDTH'(RR));
    b_req = 0; #1;
    chk("t2_a_gnt_after", WIDTH'(a_gnt), 1);
    step(); a_req = 0;
    chk("t2_a_rdata", a_rdata, init_word(8));

    // B write then A read of the same word.
    b_req = 1; b_wena = 1; b_addr = 10'h010; b_wdata = 32'hDEAD_BEEF; #1;
    chk("t3_b_gnt", WIDTH'(b_gnt), 1);
    chk("t3_ram_wena", WIDTH'(ram_wena), 1);
    step(); b_req = 0; b_wena = 0;
    a_req = 1; a_addr = 10'h010; #1;
    chk("t3_b_valid", WIDTH'(b_valid), 0);
    step(); a_req = 0;
    chk("t3_a_valid", WIDTH'(a_valid), 1);
    chk("t3_a_rdata", a_rdata, 32'hDEAD_BEEF);
    chk("t3_b_valid2", WIDTH'(b_valid), 0);

    // Locked B holds ownership for three cycles.
    a_req = 1; a_addr = 10'h001; b_req = 1; b_lock = 1; b_addr = 10'h002;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_b_gnt", WIDTH'(b_gnt), 1);
      chk("t4_a_gnt", WIDTH'(a_gnt), 0);
      step();
    end
    b_req = 0; b_lock = 0; #1;
    chk("t4_a_gnt_release", WIDTH'(a_gnt), 1);
    step();

    // Reset in the middle of a granted A read.
    a_addr = 10'h004; step();
    chk("t5_a_rdata_pre", a_rdata, 32'h1234_5678);
    a_addr = 10'h008; #1;
    chk("t5_a_gnt", WIDTH'(a_gnt), 1);
    rst_n = 0; #1;
    chk("t5_a_valid_rst", WIDTH'(a_valid), 0);
    chk("t5_a_rdata_rst", a_rdata, '0);
    a_req = 0;
    step();
    rst_n = 1;
    step();
    chk("t5_no_pulse", WIDTH'(a_valid), 0);
    step();
    chk("t5_no_pulse2", WIDTH'(a_valid), 0);

    // Random traffic obeying hold-until-grant.
    ga = 1; gb = 1;
    for (int c = 0; c < 1000; c++) begin
      if (!a_req || ga) begin
        a_req = 1'($urandom_range(0, 1));
        a_addr = DEPTH'($urandom_range(0, 15));
      end
      if (!b_req || gb) begin
        b_req = 1'($urandom_range(0, 1));
        b_wena = 1'($urandom_range(0, 1));
        b_addr = DEPTH'($urandom_range(0, 15));
        b_wdata = WIDTH'($urandom);
        b_lock = ($urandom_range(0, 3) == 0);
      end
      #1;
      ga = a_gnt; gb = b_gnt;
      step();
    end
    a_req = 0; b_req = 0; b_lock = 0; b_wena = 0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
